// File: rtl/ysyx_22050710_pkg.sv
// Shared constants for the memory-access stage:
// load op codes, FSM states and bus widths.
package ysyx_22050710_pkg;

    localparam int WORD_WD     = 64;
    localparam int PC_WD       = 64;
    localparam int INST_WD     = 32;
    localparam int GPR_ADDR_WD = 5;
    localparam int CSR_ADDR_WD = 12;

    localparam int ES_TO_MS_BUS_WD = 2 + 3 + 8 + WORD_WD + 1 + GPR_ADDR_WD
                                   + WORD_WD + 1 + CSR_ADDR_WD + WORD_WD;
    localparam int MS_TO_WS_BUS_WD = 1 + GPR_ADDR_WD + WORD_WD
                                   + 1 + CSR_ADDR_WD + WORD_WD;
    localparam int DEBUG_BUS_WD    = 1 + INST_WD + PC_WD;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LD  = 3'd3;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] LWU = 3'd6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/ysyx_22050710_load_ext.sv
// Load data extraction: pick the addressed lane out of an
// 8-byte-aligned read word and sign/zero extend it.
module ysyx_22050710_load_ext
    import ysyx_22050710_pkg::*;
(
    input  logic [2:0]         mem_op_i,
    input  logic [2:0]         addr_i,
    input  logic [WORD_WD-1:0] rdata_i,
    output logic [WORD_WD-1:0] result_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] word_v;

    // Lane select on the low address bits, then extend by op
    always_comb begin
        byte_v   = rdata_i[{addr_i, 3'b000} +: 8];
        half_v   = rdata_i[{addr_i[2:1], 4'b0000} +: 16];
        word_v   = rdata_i[{addr_i[2], 5'b00000} +: 32];
        result_o = rdata_i;
        case (mem_op_i)
            LB:      result_o = {{56{byte_v[7]}}, byte_v};
            LH:      result_o = {{48{half_v[15]}}, half_v};
            LW:      result_o = {{32{word_v[31]}}, word_v};
            LBU:     result_o = {56'd0, byte_v};
            LHU:     result_o = {48'd0, half_v};
            LWU:     result_o = {32'd0, word_v};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/ysyx_22050710_mem_stage.sv
// Memory-access pipeline stage: latches the exec bundle, runs one
// req/addr_ok/data_ok transaction for loads/stores, feeds write-back.
module ysyx_22050710_mem_stage
    import ysyx_22050710_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] i_es_to_ms_bus,
    output logic                       o_ms_allowin,
    input  logic                       i_ws_allowin,
    output logic                       o_ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] o_ms_to_ws_bus,
    output logic                       o_data_req,
    output logic                       o_data_wr,
    output logic [WORD_WD-1:0]         o_data_addr,
    output logic [7:0]                 o_data_wmask,
    output logic [WORD_WD-1:0]         o_data_wdata,
    input  logic                       i_data_addr_ok,
    input  logic                       i_data_data_ok,
    input  logic [WORD_WD-1:0]         i_data_rdata,
    output logic [GPR_ADDR_WD-1:0]     o_ms_to_ds_gpr_rd,
    output logic [CSR_ADDR_WD-1:0]     o_ms_to_ds_csr_rd,
    output logic                       o_ms_to_ds_load_busy,
    input  logic [DEBUG_BUS_WD-1:0]    i_debug_es_to_ms_bus,
    output logic [DEBUG_BUS_WD-1:0]    o_debug_ms_to_ws_bus
);

    logic                       ms_valid_q;
    logic [ES_TO_MS_BUS_WD-1:0] bus_q;
    logic [DEBUG_BUS_WD-1:0]    dbg_q;
    logic [1:0]                 state_q, state_d;
    logic [WORD_WD-1:0]         rdata_q;

    logic                   mem_ren, mem_wen, gpr_wen, csr_wen;
    logic [2:0]             mem_op;
    logic [7:0]             wmask;
    logic [WORD_WD-1:0]     wdata, alu_result, csr_result;
    logic [WORD_WD-1:0]     ld_result, gpr_result;
    logic [GPR_ADDR_WD-1:0] rd;
    logic [CSR_ADDR_WD-1:0] csr;

    logic ms_ready_go, latch, in_mem, capture;

    assign {mem_ren, mem_wen, mem_op, wmask, wdata, gpr_wen, rd,
            alu_result, csr_wen, csr, csr_result} = bus_q;

    assign in_mem = i_es_to_ms_bus[ES_TO_MS_BUS_WD-1]
                  | i_es_to_ms_bus[ES_TO_MS_BUS_WD-2];

    assign ms_ready_go  = !(mem_ren | mem_wen) || (state_q == S_DONE);
    assign o_ms_allowin = !ms_valid_q || (ms_ready_go && i_ws_allowin);
    assign latch        = i_es_to_ms_valid && o_ms_allowin;
    assign capture      = i_data_data_ok
                        && ((state_q == S_REQ && i_data_addr_ok)
                            || state_q == S_WAIT);

    // Next transaction state; data_ok outside REQ/WAIT is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (latch && in_mem) state_d = S_REQ;
            S_REQ: begin
                if (i_data_addr_ok)
                    state_d = i_data_data_ok ? S_DONE : S_WAIT;
            end
            S_WAIT: if (i_data_data_ok) state_d = S_DONE;
            default: begin
                if (i_ws_allowin)
                    state_d = (latch && in_mem) ? S_REQ : S_IDLE;
            end
        endcase
    end

    // Stage valid, payload, debug and transaction registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ms_valid_q <= 1'b0;
            bus_q      <= '0;
            dbg_q      <= '0;
            state_q    <= S_IDLE;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (o_ms_allowin) ms_valid_q <= i_es_to_ms_valid;
            if (latch) begin
                bus_q <= i_es_to_ms_bus;
                dbg_q <= i_debug_es_to_ms_bus;
            end
            if (capture) rdata_q <= i_data_rdata;
        end
    end

    ysyx_22050710_load_ext u_load_ext (
        .mem_op_i (mem_op),
        .addr_i   (alu_result[2:0]),
        .rdata_i  (rdata_q),
        .result_o (ld_result)
    );

    assign gpr_result = mem_ren ? ld_result : alu_result;

    assign o_ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign o_ms_to_ws_bus   = {gpr_wen, rd, gpr_result,
                               csr_wen, csr, csr_result};

    assign o_data_req   = (state_q == S_REQ);
    assign o_data_wr    = mem_wen;
    assign o_data_addr  = alu_result;
    assign o_data_wmask = wmask;
    assign o_data_wdata = wdata;

    assign o_ms_to_ds_gpr_rd    = (ms_valid_q && gpr_wen) ? rd : '0;
    assign o_ms_to_ds_csr_rd    = (ms_valid_q && csr_wen) ? csr : '0;
    assign o_ms_to_ds_load_busy = ms_valid_q && mem_ren && !ms_ready_go;
    assign o_debug_ms_to_ws_bus = dbg_q;

endmodule

// File: tb/tb_ysyx_22050710_mem_stage.sv
// Scoreboard bench for the memory-access stage with a
// delay-programmable data-memory slave.
module tb_ysyx_22050710_mem_stage;
    import ysyx_22050710_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst_n;
    logic                       es_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus;
    logic                       ms_allowin;
    logic                       ws_allowin;
    logic                       ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ws_bus;
    logic                       data_req, data_wr;
    logic [63:0]                data_addr, data_wdata, data_rdata;
    logic [7:0]                 data_wmask;
    logic                       addr_ok, data_ok;
    logic [4:0]                 gpr_rd;
    logic [11:0]                csr_rd;
    logic                       load_busy;
    logic [DEBUG_BUS_WD-1:0]    dbg_in, dbg_out;

    ysyx_22050710_mem_stage dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_es_to_ms_valid     (es_valid),
        .i_es_to_ms_bus       (es_bus),
        .o_ms_allowin         (ms_allowin),
        .i_ws_allowin         (ws_allowin),
        .o_ms_to_ws_valid     (ws_valid),
        .o_ms_to_ws_bus       (ws_bus),
        .o_data_req           (data_req),
        .o_data_wr            (data_wr),
        .o_data_addr          (data_addr),
        .o_data_wmask         (data_wmask),
        .o_data_wdata         (data_wdata),
        .i_data_addr_ok       (addr_ok),
        .i_data_data_ok       (data_ok),
        .i_data_rdata         (data_rdata),
        .o_ms_to_ds_gpr_rd    (gpr_rd),
        .o_ms_to_ds_csr_rd    (csr_rd),
        .o_ms_to_ds_load_busy (load_busy),
        .i_debug_es_to_ms_bus (dbg_in),
        .o_debug_ms_to_ws_bus (dbg_out)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string tag,
                         input logic [255:0] got,
                         input logic [255:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [MS_TO_WS_BUS_WD-1:0] exp_q[$];

    int          addr_dly = 0;
    int          data_dly = 0;
    logic [63:0] slv_rdata = '0;
    logic        stray = 1'b0;

    logic [63:0] exp_addr  = '0;
    logic        exp_wr    = 1'b0;
    logic [7:0]  exp_wmask = '0;
    logic [63:0] exp_wdata = '0;
    int          req_cycles  = 0;
    int          busy_cycles = 0;

    // Memory slave: addr_ok after addr_dly cycles of req,
    // data_ok data_dly cycles later (0 = same cycle).
    initial begin
        int ph;
        int cnt;
        ph = 0;
        cnt = 0;
        addr_ok = 1'b0;
        data_ok = 1'b0;
        data_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            addr_ok = 1'b0;
            data_ok = 1'b0;
            if (!rst_n) begin
                ph = 0;
            end else begin
                if (stray) data_ok = 1'b1;
                if (ph == 0 && data_req) begin
                    ph = 1;
                    cnt = addr_dly;
                end
                if (ph == 1) begin
                    if (cnt == 0) begin
                        addr_ok = 1'b1;
                        if (data_dly == 0) begin
                            data_ok = 1'b1;
                            data_rdata = slv_rdata;
                            ph = 0;
                        end else begin
                            ph = 2;
                            cnt = data_dly;
                        end
                    end else begin
                        cnt--;
                    end
                end else if (ph == 2) begin
                    cnt--;
                    if (cnt == 0) begin
                        data_ok = 1'b1;
                        data_rdata = slv_rdata;
                        ph = 0;
                    end
                end
            end
        end
    end

    // Monitor: request-side checks and scoreboard pop on transfer
    initial begin
        logic [MS_TO_WS_BUS_WD-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (load_busy) busy_cycles++;
                if (data_req) begin
                    req_cycles++;
                    check("req_addr", data_addr, exp_addr);
                    check("req_wr", data_wr, exp_wr);
                    check("req_busy", load_busy, !exp_wr);
                    if (exp_wr) begin
                        check("req_wmask", data_wmask, exp_wmask);
                        check("req_wdata", data_wdata, exp_wdata);
                    end
                end
                if (ws_valid && ws_allowin) begin
                    if (exp_q.size() == 0) begin
                        check("ws_unexpected", ws_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ws_bus", ws_bus, e);
                    end
                end
            end
        end
    end

    function automatic logic [ES_TO_MS_BUS_WD-1:0] mk_es(
        input logic        ren,
        input logic        wen,
        input logic [2:0]  op,
        input logic [7:0]  wm,
        input logic [63:0] wd,
        input logic        gw,
        input logic [4:0]  rd,
        input logic [63:0] alu,
        input logic        cw,
        input logic [11:0] csr,
        input logic [63:0] cr);
        return {ren, wen, op, wm, wd, gw, rd, alu, cw, csr, cr};
    endfunction

    // Present one bundle until the stage accepts it
    task automatic issue(input logic [ES_TO_MS_BUS_WD-1:0] bus,
                         input logic [MS_TO_WS_BUS_WD-1:0] exp);
        logic ok;
        int n;
        exp_q.push_back(exp);
        es_valid = 1'b1;
        es_bus = bus;
        n = 0;
        do begin
            @(negedge clk);
            ok = ms_allowin;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        if (!ok) check("issue_timeout", ok, 1'b1);
        es_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic mem_load(input logic [2:0]  op,
                            input logic [63:0] addr,
                            input logic [63:0] rdata,
                            input logic [63:0] exp,
                            input int ad,
                            input int dd);
        slv_rdata = rdata;
        addr_dly = ad;
        data_dly = dd;
        exp_addr = addr;
        exp_wr = 1'b0;
        issue(mk_es(1'b1, 1'b0, op, 8'h0, 64'h0, 1'b1, 5'd10,
                    addr, 1'b0, 12'h0, 64'h0),
              {1'b1, 5'd10, exp, 1'b0, 12'h0, 64'h0});
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        es_valid = 1'b0;
        es_bus = '0;
        ws_allowin = 1'b1;
        dbg_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ws_valid", ws_valid, 1'b0);
        check("rst_ws_bus", ws_bus, '0);
        check("rst_req", data_req, 1'b0);
        check("rst_gpr_rd", gpr_rd, '0);
        check("rst_busy", load_busy, 1'b0);
        check("rst_dbg", dbg_out, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU op: result one cycle later, no memory request
        req_cycles = 0;
        dbg_in = {1'b1, 32'h0000_0013, 64'h8000_0000};
        issue(mk_es(1'b0, 1'b0, LB, 8'h0, 64'h0, 1'b1, 5'd5,
                    64'h1234, 1'b0, 12'h0, 64'h0),
              {1'b1, 5'd5, 64'h1234, 1'b0, 12'h0, 64'h0});
        check("alu_valid", ws_valid, 1'b1);
        check("alu_gpr_rd", gpr_rd, 5'd5);
        check("alu_dbg", dbg_out, {1'b1, 32'h0000_0013, 64'h8000_0000});
        drain();
        check("alu_no_req", req_cycles, 0);

        // CSR-writing ALU op
        issue(mk_es(1'b0, 1'b0, LB, 8'h0, 64'h0, 1'b0, 5'd0,
                    64'h77, 1'b1, 12'h300, 64'hAB),
              {1'b0, 5'd0, 64'h77, 1'b1, 12'h300, 64'hAB});
        check("csr_rd", csr_rd, 12'h300);
        drain();

        // Load extraction / extension table
        mem_load(LB,  64'h1000_0003, 64'h80000000_FF000000,
                 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
        mem_load(LBU, 64'h1000_0003, 64'h80000000_FF000000,
                 64'hFF, 1, 1);
        mem_load(LH,  64'h1000_0006, 64'h8001_0000_0000_0000,
                 64'hFFFF_FFFF_FFFF_8001, 0, 2);
        mem_load(LHU, 64'h1000_0006, 64'h8001_0000_0000_0000,
                 64'h8001, 2, 0);
        mem_load(LW,  64'h1000_0000, 64'h1234_5678_9ABC_DEF0,
                 64'hFFFF_FFFF_9ABC_DEF0, 0, 1);
        mem_load(LWU, 64'h1000_0000, 64'h1234_5678_9ABC_DEF0,
                 64'h9ABC_DEF0, 1, 2);
        mem_load(LD,  64'h1000_0008, 64'h0123_4567_89AB_CDEF,
                 64'h0123_4567_89AB_CDEF, 0, 1);
        mem_load(LBU, 64'h1000_0005, 64'h0011_2233_4455_6677,
                 64'h22, 0, 1);

        // Delayed handshake: addr_ok after 3, data_ok 2 later
        req_cycles = 0;
        busy_cycles = 0;
        mem_load(LD, 64'h2000_0000, 64'hDEAD_BEEF_0000_0001,
                 64'hDEAD_BEEF_0000_0001, 3, 2);
        check("dly_req_cycles", req_cycles, 4);
        check("dly_busy_cycles", busy_cycles, 6);

        // addr_ok and data_ok together, LW upper word
        slv_rdata = 64'h7FFF_0000_1111_2222;
        addr_dly = 0;
        data_dly = 0;
        exp_addr = 64'h3000_0004;
        exp_wr = 1'b0;
        issue(mk_es(1'b1, 1'b0, LW, 8'h0, 64'h0, 1'b1, 5'd3,
                    64'h3000_0004, 1'b0, 12'h0, 64'h0),
              {1'b1, 5'd3, 64'h7FFF_0000, 1'b0, 12'h0, 64'h0});
        check("same_cyc_wait", ws_valid, 1'b0);
        @(posedge clk);
        #1;
        check("same_cyc_done", ws_valid, 1'b1);
        drain();

        // Store: no gpr write, result passes alu_result
        exp_addr = 64'h4000_0010;
        exp_wr = 1'b1;
        exp_wmask = 8'hF0;
        exp_wdata = 64'hCAFE_F00D_0000_0000;
        addr_dly = 1;
        data_dly = 1;
        issue(mk_es(1'b0, 1'b1, LD, 8'hF0, 64'hCAFE_F00D_0000_0000,
                    1'b0, 5'd7, 64'h4000_0010, 1'b0, 12'h0, 64'h0),
              {1'b0, 5'd7, 64'h4000_0010, 1'b0, 12'h0, 64'h0});
        drain();

        // Back-to-back loads: DONE hands straight to next REQ
        slv_rdata = 64'h0000_0000_0000_00F0;
        exp_addr = 64'h5000_0000;
        exp_wr = 1'b0;
        addr_dly = 0;
        data_dly = 1;
        issue(mk_es(1'b1, 1'b0, LBU, 8'h0, 64'h0, 1'b1, 5'd1,
                    64'h5000_0000, 1'b0, 12'h0, 64'h0),
              {1'b1, 5'd1, 64'hF0, 1'b0, 12'h0, 64'h0});
        issue(mk_es(1'b1, 1'b0, LB, 8'h0, 64'h0, 1'b1, 5'd2,
                    64'h5000_0000, 1'b0, 12'h0, 64'h0),
              {1'b1, 5'd2, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 12'h0, 64'h0});
        drain();

        // Write-back stall while DONE
        ws_allowin = 1'b0;
        req_cycles = 0;
        slv_rdata = 64'h5555_6666_7777_8888;
        exp_addr = 64'h6000_0000;
        addr_dly = 1;
        data_dly = 1;
        issue(mk_es(1'b1, 1'b0, LD, 8'h0, 64'h0, 1'b1, 5'd9,
                    64'h6000_0000, 1'b0, 12'h0, 64'h0),
              {1'b1, 5'd9, 64'h5555_6666_7777_8888, 1'b0, 12'h0, 64'h0});
        begin
            int n;
            n = 0;
            while (!ws_valid && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("bp_reach_done", ws_valid, 1'b1);
        end
        es_valid = 1'b1;
        es_bus = mk_es(1'b1, 1'b0, LD, 8'h0, 64'h0, 1'b1, 5'd4,
                       64'h7000_0000, 1'b0, 12'h0, 64'h0);
        for (int i = 0; i < 5; i++) begin
            check("bp_bus", ws_bus,
                  {1'b1, 5'd9, 64'h5555_6666_7777_8888,
                   1'b0, 12'h0, 64'h0});
            check("bp_allowin", ms_allowin, 1'b0);
            check("bp_req", data_req, 1'b0);
            @(posedge clk);
            #1;
        end
        es_valid = 1'b0;
        ws_allowin = 1'b1;
        drain();
        @(posedge clk);
        #1;
        check("bp_req_cycles", req_cycles, 2);
        check("bp_one_xfer", exp_q.size(), 0);

        // Reset while waiting for data_ok
        slv_rdata = 64'h1;
        exp_addr = 64'h8000_0000;
        addr_dly = 0;
        data_dly = 6;
        issue(mk_es(1'b1, 1'b0, LD, 8'h0, 64'h0, 1'b1, 5'd6,
                    64'h8000_0000, 1'b0, 12'h0, 64'h0),
              {1'b1, 5'd6, 64'h1, 1'b0, 12'h0, 64'h0});
        @(posedge clk);
        #1;
        check("rst_mid_busy", load_busy, 1'b1);
        check("rst_mid_noreq", data_req, 1'b0);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("rst_mid_req", data_req, 1'b0);
        check("rst_mid_valid", ws_valid, 1'b0);
        check("rst_mid_gpr_rd", gpr_rd, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        stray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stray_valid", ws_valid, 1'b0);
            check("stray_req", data_req, 1'b0);
        end
        stray = 1'b0;
        @(posedge clk);
        #1;
        issue(mk_es(1'b0, 1'b0, LB, 8'h0, 64'h0, 1'b1, 5'd8,
                    64'hBEEF, 1'b0, 12'h0, 64'h0),
              {1'b1, 5'd8, 64'hBEEF, 1'b0, 12'h0, 64'h0});
        drain();
        check("final_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
